ifetch_unit: RTL
================

// Module: ifetch_unit
// PURPOSE
//   Instruction-side producer for the single-issue MIPS core: holds the PC and fetches from
//   synchronous instruction memory. Presents the 32-bit instruction whose opcode/funct fields
//   feed the control decoder. Consumes that decoder's Branch/nBranch/Jmp/Jal/Jr flags to form
//   the next PC. Also owns the program-load path that writes the instruction memory from a byte stream.
// PARAMETERS
//   ADDR_W    14     instruction memory word-address width (depth 2**ADDR_W words)
//   RESET_PC  32'h0  PC value after reset and after leaving load mode
// PORTS
//   clock            in   1       core clock, all state updates on rising edge
//   reset            in   1       synchronous, active-high
//   run_en           in   1       1: FETCH may advance to EXEC; 0: hold in FETCH
//   Branch           in   1       beq in EXEC
//   nBranch          in   1       bne in EXEC
//   Jmp              in   1       j in EXEC
//   Jal              in   1       jal in EXEC
//   Jr               in   1       jr in EXEC
//   Zero             in   1       ALU zero flag for current instruction
//   Addr_result      in   32      branch target from ALU
//   Read_data_1      in   32      rs value (jr target)
//   imem_addr        out  ADDR_W  instruction memory word address
//   imem_rdata       in   32      memory read data, valid 1 cycle after imem_addr
//   imem_we          out  1       memory write strobe (load mode only)
//   imem_wdata       out  32      memory write data
//   ld_mode          in   1       1: program-load mode, overrides execution
//   ld_valid         in   1       ld_byte valid this cycle
//   ld_byte          in   8       load stream byte, little-endian within a word
//   ld_done          out  1       1-cycle pulse when ld_mode falls
//   Instruction      out  32      current instruction; 0 when instr_valid=0
//   instr_valid      out  1       1 for exactly one cycle per executed instruction (EXEC)
//   pc_out           out  32      current PC
//   branch_base_addr out  32      pc_out+4
//   link_addr        out  32      return address latched by jal
// BEHAVIOUR
//   Reset: state=FETCH, pc_out=RESET_PC, link_addr=0, instr_valid=0, imem_we=0, ld_done=0,
//     loader pointer=0, byte count=0. Same result if reset asserts mid-fetch or mid-load.
//   States:
//     FETCH -> EXEC when run_en=1 && ld_mode=0.
//     EXEC -> FETCH always.
//     any -> LOAD when ld_mode=1.
//     LOAD -> FETCH when ld_mode=0.
//   imem_addr = pc_out[ADDR_W+1:2] in FETCH/EXEC. PC bits above ADDR_W+1 ignored (alias).
//   EXEC: instr_valid=1, Instruction=imem_rdata. Next PC at end of EXEC, in priority order:
//     Jr                       -> {Read_data_1[31:2],2'b00}
//     Jmp|Jal                  -> {pc+4[31:28], Instruction[25:0], 2'b00}
//     Branch&Zero | nBranch&!Zero -> Addr_result
//     otherwise                -> pc+4
//   Jal in EXEC: link_addr <= pc+4. Addition wraps mod 2**32.
//   Fetch latency: 2 cycles per instruction (FETCH + EXEC). Control inputs are sampled in EXEC only.
//   LOAD:
//     - Each ld_valid byte is shifted into the word at position count; count increments 0..3.
//     - On the 4th byte: imem_we=1 for one cycle, imem_addr=ptr, imem_wdata=assembled word.
//     - Then ptr++ (wraps at 2**ADDR_W) and count=0.
//     - ld_valid ignored when ld_mode=0.
//   ld_mode falling: partial word (count!=0) discarded, ptr=0, pc_out=RESET_PC, ld_done=1 for
//     one cycle, state FETCH. ld_mode rising during EXEC aborts that instruction (PC unchanged).
// STRUCTURE
//   Shared header cpu_defs.vh: state encoding, RESET_PC default, opcode/funct constants
//   shared with the control decoder.
//   One sub-module imem_loader: byte-to-word assembler + write pointer
//   (clock, reset, ld_mode, ld_valid, ld_byte -> we, waddr, wdata).
// TESTING
//   1. Reset, ROM word0=addi at 0x0 -> pc 0x0,0x4,0x8 on successive EXECs; instr_valid pulses every 2nd cycle.
//   2. beq with Zero=1, Addr_result=0x40 -> next pc_out=0x40; Zero=0 -> 0x4; bne mirrored.
//   3. jal 0x0000010 at pc 0x8 -> pc 0x40, link_addr 0xC; jr with Read_data_1=0xD -> pc 0xC.
//   4. Load bytes 78 56 34 12 EF BE -> one write 0x12345678 at addr 0; drop ld_mode -> partial discarded, ld_done, pc 0.
//   5. run_en=0 for 5 cycles -> no instr_valid, pc frozen; reset mid-EXEC -> pc RESET_PC, no PC update.
//   6. ADDR_W=2, load 5 words -> 5th write lands at addr 0 (wrap).

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-side definitions: FSM encoding, reset PC, opcode/funct constants, next-PC helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_LOAD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Opcode/funct values shared with the control decoder.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Next PC in priority order: jr, j/jal, taken branch, sequential.
    function automatic logic [31:0] next_pc(
        input logic [31:0] pc4,
        input logic [25:0] jidx,
        input logic [31:0] rs_val,
        input logic [31:0] br_target,
        input logic        is_jr,
        input logic        is_jmp,
        input logic        taken
    );
        logic [31:0] npc;
        if (is_jr)       npc = rs_val & 32'hFFFF_FFFC;
        else if (is_jmp) npc = {pc4[31:28], jidx, 2'b00};
        else if (taken)  npc = br_target;
        else             npc = pc4;
        return npc;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and a synchronous RAM (slave).
// Latency: imem_rdata is valid one cycle after imem_addr.
// Backpressure: none; the memory always accepts reads and writes.
//   imem_addr  : word address          imem_we    : write strobe
//   imem_wdata : write data            imem_rdata : read data
interface ifetch_unit_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [31:0]       imem_wdata;
    logic [31:0]       imem_rdata;

    modport master (output imem_addr, imem_we, imem_wdata, input imem_rdata);
    modport slave  (input imem_addr, imem_we, imem_wdata, output imem_rdata);
endinterface

// File: rtl/ifetch_unit_imem_loader.sv
// Byte-stream to word assembler with a wrapping write pointer for program load.
// Latency: write strobe one cycle after the 4th byte of a word is accepted.
// Backpressure: none; every ld_valid byte in load mode is consumed.
//   in : clock, reset, ld_mode, ld_valid, ld_byte[7:0]
//   out: we, waddr[ADDR_W-1:0], wdata[31:0]
module ifetch_unit_imem_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_mode,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata
);
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    logic [1:0]        count;
    logic [23:0]       shreg;
    logic [ADDR_W-1:0] ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            count <= 2'd0;
            shreg <= '0;
            ptr   <= '0;
        end else begin
            we <= 1'b0;
            if (!ld_mode) begin
                // Leaving or outside load mode: drop any partial word, rewind.
                ptr   <= '0;
                count <= 2'd0;
            end else if (ld_valid) begin
                if (count == 2'd3) begin
                    // Bytes arrive LSB first, so the newest byte is the top byte.
                    we    <= 1'b1;
                    waddr <= ptr;
                    wdata <= {ld_byte, shreg};
                    ptr   <= ptr + PTR_ONE;
                    count <= 2'd0;
                end else begin
                    shreg <= {ld_byte, shreg[23:8]};
                    count <= count + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// PC holder and instruction fetcher for the single-issue core, plus program-load path.
// Latency: 2 cycles per instruction (FETCH, EXEC); control flags sampled in EXEC only.
// Backpressure: run_en=0 holds in FETCH; ld_mode=1 preempts everything, aborting EXEC.
//   clock/reset        : core clock, synchronous active-high reset
//   run_en             : permit FETCH->EXEC
//   Branch..Jr, Zero   : decoder flags and ALU zero for the instruction in EXEC
//   Addr_result        : branch target      Read_data_1 : jr target
//   imem               : instruction memory bus (master)
//   ld_mode/valid/byte : program-load stream  ld_done : pulse after leaving load mode
//   Instruction, instr_valid, pc_out, branch_base_addr, link_addr : fetch results
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run_en,
    input  logic                 Branch,
    input  logic                 nBranch,
    input  logic                 Jmp,
    input  logic                 Jal,
    input  logic                 Jr,
    input  logic                 Zero,
    input  logic [31:0]          Addr_result,
    input  logic [31:0]          Read_data_1,
    ifetch_unit_if.master        imem,
    input  logic                 ld_mode,
    input  logic                 ld_valid,
    input  logic [7:0]           ld_byte,
    output logic                 ld_done,
    output logic [31:0]          Instruction,
    output logic                 instr_valid,
    output logic [31:0]          pc_out,
    output logic [31:0]          branch_base_addr,
    output logic [31:0]          link_addr
);
    fetch_state_t      state_q, state_d;
    logic [31:0]       pc_q;
    logic [31:0]       pc4;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_waddr;
    logic [31:0]       ld_wdata;
    logic              taken;
    logic              load_exit;

    ifetch_unit_imem_loader #(.ADDR_W(ADDR_W)) u_loader (
        .clock    (clock),
        .reset    (reset),
        .ld_mode  (ld_mode),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .we       (ld_we),
        .waddr    (ld_waddr),
        .wdata    (ld_wdata)
    );

    always_comb begin
        state_d = state_q;
        if (ld_mode) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_FETCH: if (run_en) state_d = S_EXEC;
                S_EXEC:  state_d = S_FETCH;
                S_LOAD:  state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // An EXEC cycle with ld_mode raised is aborted: not reported, PC untouched.
    assign instr_valid      = (state_q == S_EXEC) && !ld_mode;
    assign Instruction      = instr_valid ? imem.imem_rdata : 32'h0;
    assign pc4              = pc_q + 32'd4;
    assign pc_out           = pc_q;
    assign branch_base_addr = pc4;
    assign taken            = (Branch & Zero) | (nBranch & ~Zero);
    assign load_exit        = (state_q == S_LOAD) && !ld_mode;

    // A pending loader write owns the address bus; otherwise the PC drives it
    // (upper PC bits alias onto the memory).
    assign imem.imem_addr  = ld_we ? ld_waddr : pc_q[ADDR_W+1:2];
    assign imem.imem_we    = ld_we;
    assign imem.imem_wdata = ld_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            link_addr <= 32'h0;
            ld_done   <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_done <= load_exit;
            if (load_exit) begin
                pc_q <= RESET_PC;
            end else if (instr_valid) begin
                pc_q <= next_pc(pc4, imem.imem_rdata[25:0], Read_data_1, Addr_result,
                                Jr, Jmp | Jal, taken);
                if (Jal) link_addr <= pc4;
            end
        end
    end

endmodule
